// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side byte FIFO that fetches from an upstream UART and serves a CPU register port
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_int,
    input  logic [7:0] i_rx_dat,
    output logic       o_rx_cyc,
    output logic       o_rx_addr,
    output logic       o_rx_we,
    input  logic       i_cyc,
    input  logic       i_we,
    input  logic       i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    output logic       o_int
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] THR = (AW + 1)'(THRESHOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_d;
    logic        ov_q, ov_d;
    logic        int_q, int_d;
    logic [7:0]  mem_q [DEPTH];

    logic empty, full;
    logic cpu_rd_data, cpu_rd_stat, flush;
    logic push_req, push_ok, pop, overflow;
    logic unused_dat;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign cpu_rd_data = i_cyc && !i_we && !i_addr;
    assign cpu_rd_stat = i_cyc && !i_we && i_addr;
    assign flush       = i_cyc && i_we && i_addr && i_dat[0];
    assign unused_dat  = ^i_dat[7:1];

    // The byte sampled at the end of FETCH is the push; a flush in the same cycle drops it.
    assign push_req = (state_q == FETCH);
    assign pop      = cpu_rd_data && !empty;
    assign push_ok  = push_req && !flush && (!full || pop);
    assign overflow = push_req && !flush && full && !pop;

    assign o_rx_cyc  = (state_q == FETCH);
    assign o_rx_addr = 1'b0;
    assign o_rx_we   = 1'b0;
    assign o_int     = int_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (i_rx_int || pending_q) begin
                    state_d = FETCH;
                end
                // If both a fresh pulse and a pending one exist, one is consumed now.
                pending_d = pending_q && i_rx_int;
            end
            FETCH: begin
                state_d   = IDLE;
                pending_d = pending_q || i_rx_int;
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ov_d     = ov_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            ov_d     = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (overflow) begin
                ov_d = 1'b1;
            end else if (cpu_rd_stat) begin
                ov_d = 1'b0;
            end
        end
        level_d = wr_ptr_d - rd_ptr_d;
        int_d   = (level_d >= THR);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ov_q      <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ov_q      <= ov_d;
            int_q     <= int_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_rx_dat;
        end
    end

    always_comb begin
        o_dat = 8'h00;
        if (i_addr) begin
            o_dat = {5'd0, full, ov_q, !empty};
        end else if (!empty) begin
            o_dat = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_int = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       rx_cyc, rx_addr, rx_we;
    logic       cyc = 1'b0, we = 1'b0, addr = 1'b0;
    logic [7:0] wdat = 8'h00;
    logic [7:0] rdat;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] up_q[$];
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(16), .THRESHOLD(1)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_rx_int  (rx_int),
        .i_rx_dat  (rx_dat),
        .o_rx_cyc  (rx_cyc),
        .o_rx_addr (rx_addr),
        .o_rx_we   (rx_we),
        .i_cyc     (cyc),
        .i_we      (we),
        .i_addr    (addr),
        .i_dat     (wdat),
        .o_dat     (rdat),
        .o_int     (irq)
    );

    always #5 clk = ~clk;

    // Upstream receiver: presents the head of its queue, consumes one byte per fetch.
    always @(negedge clk) rx_dat = (up_q.size() > 0) ? up_q[0] : 8'h00;
    always @(posedge clk) if (rx_cyc && up_q.size() > 0) void'(up_q.pop_front());

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx(input logic [7:0] b, input bit store);
        up_q.push_back(b);
        if (store) exp_q.push_back(b);
        rx_int = 1'b1;
        tick();
        rx_int = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        cyc = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdat;
        tick();
        cyc = 1'b0; addr = 1'b0;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        cyc = 1'b1; we = 1'b1; addr = a; wdat = d;
        tick();
        cyc = 1'b0; we = 1'b0; addr = 1'b0; wdat = 8'h00;
    endtask

    task automatic peek_status(output logic [7:0] s);
        addr = 1'b1;
        #1;
        s = rdat;
        addr = 1'b0;
    endtask

    task automatic read_expect(input string name);
        logic [7:0] d, e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        cpu_read(1'b0, d);
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, d, e);
        end
    endtask

    task automatic test_reset();
        logic [7:0] s, d;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (rx_cyc !== 1'b0 || irq !== 1'b0 || rx_addr !== 1'b0 || rx_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cyc=%b int=%b addr=%b we=%b expected 0000", rx_cyc, irq, rx_addr, rx_we);
        end
        peek_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL reset_status: got %02h expected 00", s); end
        cpu_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL empty_read: got %02h expected 00", d); end
        peek_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL empty_read_status: got %02h expected 00", s); end
    endtask

    task automatic test_single();
        logic [7:0] s;
        pulse_rx(8'h5A, 1'b1);
        checks++;
        if (rx_cyc !== 1'b1) begin errors++; $display("FAIL single_fetch_on: got %b expected 1", rx_cyc); end
        tick();
        checks++;
        if (rx_cyc !== 1'b0) begin errors++; $display("FAIL single_fetch_off: got %b expected 0", rx_cyc); end
        peek_status(s);
        checks++;
        if (s !== 8'h01 || irq !== 1'b1) begin
            errors++;
            $display("FAIL single_status: got %02h int=%b expected 01 int=1", s, irq);
        end
        read_expect("single_data");
        peek_status(s);
        checks++;
        if (s !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_drained: got %02h int=%b expected 00 int=0", s, irq);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s, d;
        for (int i = 0; i < 17; i++) begin
            pulse_rx(8'(i), i < 16);
            tick();
        end
        peek_status(s);
        checks++;
        if (s !== 8'h07) begin errors++; $display("FAIL ovf_status: got %02h expected 07", s); end
        for (int i = 0; i < 16; i++) read_expect("ovf_order");
        peek_status(s);
        checks++;
        if (s !== 8'h02) begin errors++; $display("FAIL ovf_sticky: got %02h expected 02", s); end
        cpu_read(1'b1, d);
        peek_status(s);
        checks++;
        if (s !== 8'h00) begin errors++; $display("FAIL ovf_clear: got %02h expected 00", s); end
    endtask

    task automatic test_pending();
        logic [7:0] s;
        pulse_rx(8'hA1, 1'b1);
        pulse_rx(8'hB2, 1'b1);
        checks++;
        if (rx_cyc !== 1'b0) begin errors++; $display("FAIL pend_gap: got %b expected 0", rx_cyc); end
        tick();
        checks++;
        if (rx_cyc !== 1'b1) begin errors++; $display("FAIL pend_refetch: got %b expected 1", rx_cyc); end
        tick();
        peek_status(s);
        checks++;
        if (s !== 8'h01) begin errors++; $display("FAIL pend_status: got %02h expected 01", s); end
        read_expect("pend_first");
        read_expect("pend_second");
    endtask

    task automatic test_full_push_pop();
        logic [7:0] s;
        for (int i = 0; i < 16; i++) begin
            pulse_rx(8'hC0 + 8'(i), 1'b1);
            tick();
        end
        pulse_rx(8'hD0, 1'b1);
        read_expect("fpp_pop");
        peek_status(s);
        checks++;
        if (s !== 8'h05) begin errors++; $display("FAIL fpp_status: got %02h expected 05", s); end
        for (int i = 0; i < 16; i++) read_expect("fpp_order");
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL fpp_int: got %b expected 0", irq); end
    endtask

    task automatic test_flush_and_reset();
        logic [7:0] s;
        for (int i = 0; i < 3; i++) begin
            pulse_rx(8'h30 + 8'(i), 1'b0);
            tick();
        end
        cpu_write(1'b0, 8'h01);
        cpu_write(1'b1, 8'h00);
        peek_status(s);
        checks++;
        if (s !== 8'h01 || irq !== 1'b1) begin
            errors++;
            $display("FAIL ignored_writes: got %02h int=%b expected 01 int=1", s, irq);
        end
        cpu_write(1'b1, 8'h01);
        peek_status(s);
        checks++;
        if (s !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL flush: got %02h int=%b expected 00 int=0", s, irq);
        end
        pulse_rx(8'h77, 1'b0);
        checks++;
        if (rx_cyc !== 1'b1) begin errors++; $display("FAIL rst_fetch_on: got %b expected 1", rx_cyc); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        peek_status(s);
        checks++;
        if (rx_cyc !== 1'b0 || s !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_fetch: cyc=%b status=%02h int=%b expected 0 00 0", rx_cyc, s, irq);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_pending();
        test_full_push_pop();
        test_flush_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
